// File: rtl/button_events_pkg.sv
// Shared types for the debounced button event block: event codes and the
// per-button debounce state machine encoding.
package button_events_pkg;

  typedef enum logic [1:0] {
    EVT_NONE    = 2'd0,
    EVT_PRESS   = 2'd1,
    EVT_RELEASE = 2'd2,
    EVT_LONG    = 2'd3
  } evt_type_t;

  typedef enum logic [1:0] {
    RELEASED,
    PRESS_WAIT,
    PRESSED,
    RELEASE_WAIT
  } btn_state_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/button_debounce.sv
// One button: 2-flop synchronizer, debounce/long-hold FSM and a single-entry
// event slot that the top-level arbiter drains.
module button_debounce
  import button_events_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int LONG_CYCLES     = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       button_i,
  input  logic       slot_clear_i,
  output logic       slot_valid_o,
  output logic [1:0] slot_type_o,
  output logic       pressed_o
);

  localparam int CNT_MAX = max_int(DEBOUNCE_CYCLES, LONG_CYCLES);
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] DEB  = CW'(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] LONG = CW'(LONG_CYCLES);
  localparam logic [CW-1:0] ONE  = CW'(1);

  logic         meta;
  logic         sync;
  btn_state_t   state;
  logic [CW-1:0] cnt;
  logic         long_done;
  logic         slot_valid;
  evt_type_t    slot_type;
  logic         pressed;

  // NOTE: the synchronizer works on the inverted (active-high) button, so
  // resetting both flops to 0 means "released" rather than "pressed".
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      sync <= 1'b0;
    end else begin
      meta <= ~button_i;
      sync <= meta;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= RELEASED;
      cnt        <= '0;
      long_done  <= 1'b0;
      slot_valid <= 1'b0;
      slot_type  <= EVT_NONE;
      pressed    <= 1'b0;
    end else begin
      // NOTE: the clear only arrives while the slot is full and commits only
      // happen while it is empty, so the later commit assignments never race it.
      if (slot_clear_i) slot_valid <= 1'b0;

      case (state)
        RELEASED: begin
          if (sync) begin
            state <= PRESS_WAIT;
            cnt   <= ONE;
          end
        end

        PRESS_WAIT: begin
          if (!sync) begin
            state <= RELEASED;
            cnt   <= '0;
          end else if (cnt < DEB) begin
            cnt <= cnt + ONE;
          end else if (!slot_valid) begin
            state      <= PRESSED;
            cnt        <= '0;
            long_done  <= 1'b0;
            slot_valid <= 1'b1;
            slot_type  <= EVT_PRESS;
            pressed    <= 1'b1;
          end
        end

        PRESSED: begin
          if (!sync) begin
            state <= RELEASE_WAIT;
            cnt   <= ONE;
          end else if (LONG_CYCLES > 0 && !long_done) begin
            if (cnt < LONG) begin
              cnt <= cnt + ONE;
            end else if (!slot_valid) begin
              slot_valid <= 1'b1;
              slot_type  <= EVT_LONG;
              long_done  <= 1'b1;
            end
          end
        end

        RELEASE_WAIT: begin
          // A bounce back to pressed restarts long timing unless LONG already fired.
          if (sync) begin
            state <= PRESSED;
            if (!long_done) cnt <= '0;
          end else if (cnt < DEB) begin
            cnt <= cnt + ONE;
          end else if (!slot_valid) begin
            state      <= RELEASED;
            cnt        <= '0;
            slot_valid <= 1'b1;
            slot_type  <= EVT_RELEASE;
            pressed    <= 1'b0;
          end
        end

        default: state <= RELEASED;
      endcase
    end
  end

  assign slot_valid_o = slot_valid;
  assign slot_type_o  = slot_type;
  assign pressed_o    = pressed;

endmodule

// File: rtl/button_events.sv
// Debounced button events: one button_debounce per input, a fixed-priority
// arbiter over the event slots and a valid/ready output register.
module button_events
  import button_events_pkg::*;
#(
  parameter int NUM_BUTTONS     = 3,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int LONG_CYCLES     = 16
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_BUTTONS-1:0]         button_i,
  output logic [NUM_BUTTONS-1:0]         pressed_o,
  output logic                           evt_valid_o,
  input  logic                           evt_ready_i,
  output logic [$clog2(NUM_BUTTONS)-1:0] evt_button_o,
  output logic [1:0]                     evt_type_o
);

  localparam int BW = $clog2(NUM_BUTTONS);

  logic [NUM_BUTTONS-1:0] slot_valid;
  logic [1:0]             slot_type [NUM_BUTTONS];
  logic [NUM_BUTTONS-1:0] slot_clear;

  for (genvar g = 0; g < NUM_BUTTONS; g++) begin : g_btn
    button_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .LONG_CYCLES    (LONG_CYCLES)
    ) u_debounce (
      .clk         (clk),
      .rst_n       (rst_n),
      .button_i    (button_i[g]),
      .slot_clear_i(slot_clear[g]),
      .slot_valid_o(slot_valid[g]),
      .slot_type_o (slot_type[g]),
      .pressed_o   (pressed_o[g])
    );
  end

  logic          load;
  logic          sel_found;
  logic [BW-1:0] sel_idx;
  logic [1:0]    sel_type;

  // NOTE: every always_comb output gets a default before the loop so no latch
  // is inferred when no slot is full.
  always_comb begin
    load       = !evt_valid_o || evt_ready_i;
    sel_found  = 1'b0;
    sel_idx    = '0;
    sel_type   = EVT_NONE;
    slot_clear = '0;
    for (int i = 0; i < NUM_BUTTONS; i++) begin
      if (slot_valid[i] && !sel_found) begin
        sel_found     = 1'b1;
        sel_idx       = BW'(i);
        sel_type      = slot_type[i];
        slot_clear[i] = load;
      end
    end
  end

  // Holding the register while valid && !ready keeps button/type stable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      evt_valid_o  <= 1'b0;
      evt_button_o <= '0;
      evt_type_o   <= EVT_NONE;
    end else if (load) begin
      evt_valid_o  <= sel_found;
      evt_button_o <= sel_idx;
      evt_type_o   <= sel_type;
    end
  end

endmodule

// File: doc/button_events.md
Name: button_events

Overview:
- Input-side counterpart to the LED driver logic. It turns the raw active-low board buttons into clean, debounced, timestamp-free events.
- Event types: PRESS, LONG (held), RELEASE.
- Events are delivered one at a time over a valid/ready interface to whatever LED or control logic sits above.
- It also provides a debounced level per button.

Parameters:
- NUM_BUTTONS, 3, number of active-low button inputs.
- DEBOUNCE_CYCLES, 4, number of consecutive stable synchronized samples needed to accept a change. Must be >= 1. FPGA instantiation overrides it, e.g. 250000.
- LONG_CYCLES, 16, cycles held after PRESS before LONG is reported. 0 disables LONG. If nonzero, must be > DEBOUNCE_CYCLES.

Ports:
- clk  in  1  single clock for all logic.
- rst_n  in  1  asynchronous, active-low reset. Assertion is asynchronous. Deassertion is synchronized externally.
- button_i  in  NUM_BUTTONS  raw active-low buttons (0 = pressed), asynchronous to clk.
- pressed_o  out  NUM_BUTTONS  debounced level per button (1 = held).
- evt_valid_o  out  1  event available.
- evt_ready_i  in  1  consumer accepts the event on a clk edge where valid && ready.
- evt_button_o  out  $clog2(NUM_BUTTONS)  index of the button that caused the event.
- evt_type_o  out  2  event type: 0 NONE, 1 PRESS, 2 RELEASE, 3 LONG.

Behaviour:
- Reset values: all outputs 0. Sync flops 0 (treated as released). Every FSM in RELEASED. Counters 0. Slots empty. long_done 0.
- Synchronizer: 2-flop per button on ~button_i. The value after the 2nd flop is called sync.
- Per-button state: 4-state FSM, counter cnt sized $clog2(max(DEBOUNCE_CYCLES, LONG_CYCLES)+1), one event slot (valid + type), and long_done.
- RELEASED:
  - sync=1: go to PRESS_WAIT, cnt<-1.
- PRESS_WAIT:
  - sync=0: go to RELEASED, cnt<-0.
  - sync=1, cnt<DEB: cnt++.
  - sync=1, cnt==DEB, slot empty: go to PRESSED, cnt<-0, long_done<-0, slot<-PRESS.
  - slot full: hold state, cnt saturated.
- PRESSED:
  - sync=0: go to RELEASE_WAIT, cnt<-1.
  - LONG_CYCLES>0, !long_done, cnt<LONG: cnt++.
  - cnt==LONG, slot empty: slot<-LONG, long_done<-1.
  - slot full: cnt saturates.
- RELEASE_WAIT:
  - sync=1 (bounce): go to PRESSED. cnt<-0 if !long_done, else cnt unchanged.
  - sync=0, cnt<DEB: cnt++.
  - sync=0, cnt==DEB, slot empty: go to RELEASED, cnt<-0, slot<-RELEASE.
  - slot full: hold.
- pressed_o[i] = 1 in PRESSED and RELEASE_WAIT.
- One slot per button: a new event is never committed over an unconsumed one, so per-button ordering is always PRESS, [LONG], RELEASE. No events are dropped.
- Slot-full test uses the registered slot value. A slot freed on edge n is reusable from edge n+1.
- Output register:
  - Loads when !evt_valid_o || evt_ready_i.
  - Takes the lowest-index full slot and clears that slot on the same edge.
  - If no slot is full and ready was 1, evt_valid_o drops to 0.
- Output stability: while valid && !ready, evt_button_o and evt_type_o are held stable.
- Fixed priority cannot starve higher indices, because debounce limits the event rate.
- Latency: button_i falls before edge k. sync=1 at edge k+2. PRESS commits to the slot at edge k+2+DEB. evt_valid_o rises after edge k+3+DEB (after edge k+7 at defaults), given an idle output.
- Reset mid-operation: pending slots and the output event are discarded immediately. If a button is still held after reset release, it produces a fresh PRESS after debounce.

Decomposition:
- Package button_events_pkg holds:
  - evt_type_t enum (EVT_NONE=0, EVT_PRESS=1, EVT_RELEASE=2, EVT_LONG=3).
  - btn_state_t enum (RELEASED, PRESS_WAIT, PRESSED, RELEASE_WAIT).
- Sub-module button_debounce, one per button via generate. It contains the synchronizer, FSM, counter, long_done and slot, with ports:
  - slot_valid_o
  - slot_type_o
  - slot_clear_i
  - pressed_o
- Top level: arbiter and output register only.

Test Plan (defaults DEB=4, LONG=16, evt_ready_i=1 unless stated):
- Reset: rst_n=0 with button_i=3'b000, then release and hold all three buttons -> all outputs 0 during reset. After reset, PRESS for buttons 0, 1, 2 in that order, one per accepted cycle.
- Clean hold of button 1: button_i[1] low before edge k, held 40 cycles -> PRESS (btn 1) valid after edge k+7. pressed_o[1]=1 from edge k+6. LONG valid after edge k+24. After release, RELEASE valid 8 cycles after button_i returns high.
- Bounce: button_i[0] low 3 cycles then high, repeated 5 times -> no event, pressed_o[0] stays 0.
- Backpressure: evt_ready_i=0, press buttons 0 and 2 together, release button 0 after 10 cycles -> output holds btn 0 PRESS stable for 30 cycles. Then pulse ready once per event -> btn 0 PRESS, btn 0 RELEASE, btn 2 PRESS in that order, with no losses.
- Short press: button 2 held 10 cycles -> PRESS then RELEASE, no LONG.
- Async reset mid-event: evt_valid_o=1, assert rst_n between edges -> evt_valid_o=0 without a clock edge. With the button still held, release rst_n -> PRESS re-reported after 7 edges.
